// File: rtl/fetch_controller_if.sv
// Core/program-memory side signals of the fetch sequencer, bundled so the
// decode/control stage (master) and fetch_controller (slave) share one port.
interface fetch_controller_if #(
  parameter int ADDR_WIDTH = 13
);
  // Handshake: exec_valid qualifies exec_pc every cycle. The core consumes the
  // instruction in a cycle where exec_valid=1 and stall=0; stall is the only
  // backpressure, and redirects are accepted in the cycle they are asserted.
  logic                  stall;
  logic                  jump_en;
  logic                  call_en;
  logic                  ret_en;
  logic                  skip_en;
  logic [ADDR_WIDTH-1:0] target;

  logic [ADDR_WIDTH-1:0] pm_addr;
  logic                  pm_rd_en;
  logic                  pm_flush;

  logic [ADDR_WIDTH-1:0] exec_pc;
  logic                  exec_valid;
  logic                  stk_ovf;
  logic                  stk_unf;

  modport master (
    output stall, jump_en, call_en, ret_en, skip_en, target,
    input  pm_addr, pm_rd_en, pm_flush, exec_pc, exec_valid, stk_ovf, stk_unf
  );

  modport slave (
    input  stall, jump_en, call_en, ret_en, skip_en, target,
    output pm_addr, pm_rd_en, pm_flush, exec_pc, exec_valid, stk_ovf, stk_unf
  );
endinterface

// File: rtl/fetch_controller.sv
// Program-counter sequencer for a 2-stage program memory (addr -> word reg -> instr reg)
// with goto/call/return/skip redirects and a circular hardware return stack.
module fetch_controller #(
  parameter int                    ADDR_WIDTH   = 13,
  parameter int                    STACK_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_controller_if.slave bus
);

  localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  addr_t            fetch_pc_q, fetch_pc_d;
  addr_t            word_pc_q,  word_pc_d;
  addr_t            exec_pc_q,  exec_pc_d;
  logic             exec_valid_q, exec_valid_d;
  logic             flush_d1_q, flush_d1_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  addr_t            stack_q [STACK_DEPTH];

  logic  do_call, do_jump, do_ret, redirect;
  logic  pm_flush_w, pm_rd_en_w;
  addr_t pm_addr_w;
  addr_t pop_addr;
  addr_t push_addr;

  // Conflicting requests resolve call > jump > ret; skip only adds a bubble.
  assign do_call  = bus.call_en;
  assign do_jump  = bus.jump_en & ~bus.call_en;
  assign do_ret   = bus.ret_en & ~bus.call_en & ~bus.jump_en;
  assign redirect = bus.jump_en | bus.call_en | bus.ret_en;

  assign pop_addr  = stack_q[sp_q - SP_W'(1)];
  assign push_addr = exec_pc_q + addr_t'(1);

  // A redirect needs two flushes: the word already in the memory's internal
  // register and the one being addressed this cycle are both on the old path.
  assign pm_flush_w = redirect | bus.skip_en | flush_d1_q;
  assign pm_rd_en_w = ~bus.stall | pm_flush_w;
  // Stall re-presents word_pc so the in-flight word survives the reload.
  assign pm_addr_w  = (bus.stall & ~redirect) ? word_pc_q : fetch_pc_q;

  assign bus.pm_addr    = pm_addr_w;
  assign bus.pm_rd_en   = pm_rd_en_w;
  assign bus.pm_flush   = pm_flush_w;
  assign bus.exec_pc    = exec_pc_q;
  assign bus.exec_valid = exec_valid_q;
  assign bus.stk_ovf    = ovf_q;
  assign bus.stk_unf    = unf_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    word_pc_d    = pm_addr_w;
    exec_pc_d    = exec_pc_q;
    exec_valid_d = exec_valid_q;
    flush_d1_d   = redirect;
    sp_d         = sp_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;

    if (pm_flush_w) begin
      exec_valid_d = 1'b0;
    end else if (pm_rd_en_w) begin
      exec_pc_d    = word_pc_q;
      exec_valid_d = 1'b1;
    end

    if (do_call || do_jump) begin
      fetch_pc_d = bus.target;
    end else if (do_ret) begin
      fetch_pc_d = pop_addr;
    end else if (!bus.stall) begin
      fetch_pc_d = fetch_pc_q + addr_t'(1);
    end

    // Stack is circular: overflow overwrites the oldest entry, underflow
    // pops whatever stale entry sits below sp.
    if (do_call) begin
      sp_d = sp_q + SP_W'(1);
      if (count_q == CNT_W'(STACK_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (do_ret) begin
      sp_d = sp_q - SP_W'(1);
      if (count_q == '0) begin
        unf_d = 1'b1;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_VECTOR;
      word_pc_q    <= '0;
      exec_pc_q    <= '0;
      exec_valid_q <= 1'b0;
      flush_d1_q   <= 1'b1;
      sp_q         <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      word_pc_q    <= word_pc_d;
      exec_pc_q    <= exec_pc_d;
      exec_valid_q <= exec_valid_d;
      flush_d1_q   <= flush_d1_d;
      sp_q         <= sp_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      if (do_call) begin
        stack_q[sp_q] <= push_addr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: expected executed addresses are queued as
// stimulus is driven and popped whenever the core would consume an instruction.
module tb_fetch_controller;
  localparam int AW = 13;

  logic clk;
  logic rst_n;

  fetch_controller_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_controller #(
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (8),
    .RESET_VECTOR(13'h0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] model_pc;
  logic [AW-1:0] ret_addr [9];
  int            n_pass;
  int            n_fail;
  int            n_total;
  int            used;

  logic          s_flush, s_valid, s_rd_en;
  logic [AW-1:0] s_pc, s_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, consume an instruction if the core would, then step past posedge.
  task automatic tick();
    logic [AW-1:0] e;
    @(negedge clk);
    s_flush = bus.pm_flush;
    s_valid = bus.exec_valid;
    s_rd_en = bus.pm_rd_en;
    s_pc    = bus.exec_pc;
    s_addr  = bus.pm_addr;
    if (bus.exec_valid && !bus.stall) begin
      if (exp_q.size() == 0) begin
        chk("spurious_exec_valid", 32'(bus.exec_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("exec_pc", 32'(bus.exec_pc), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run(input int n, output int cycles);
    for (int i = 0; i < n; i++) exp_q.push_back(model_pc + AW'(i));
    model_pc = model_pc + AW'(n);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < n + 8) begin
      tick();
      cycles++;
    end
    chk("run_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_jump(input logic [AW-1:0] t);
    exp_q.push_back(model_pc);
    bus.jump_en = 1'b1;
    bus.target  = t;
    tick();
    chk("jump_flush", 32'(s_flush), 32'd1);
    bus.jump_en = 1'b0;
    model_pc    = t;
  endtask

  task automatic do_call(input logic [AW-1:0] t);
    exp_q.push_back(model_pc);
    bus.call_en = 1'b1;
    bus.target  = t;
    tick();
    chk("call_flush", 32'(s_flush), 32'd1);
    bus.call_en = 1'b0;
    model_pc    = t;
  endtask

  task automatic do_ret(input logic [AW-1:0] landing);
    exp_q.push_back(model_pc);
    bus.ret_en = 1'b1;
    tick();
    chk("ret_flush", 32'(s_flush), 32'd1);
    bus.ret_en = 1'b0;
    model_pc   = landing;
  endtask

  task automatic do_skip();
    exp_q.push_back(model_pc);
    bus.skip_en = 1'b1;
    tick();
    chk("skip_flush", 32'(s_flush), 32'd1);
    bus.skip_en = 1'b0;
    model_pc    = model_pc + AW'(2);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    bus.stall = 1'b0; bus.jump_en = 1'b0; bus.call_en = 1'b0;
    bus.ret_en = 1'b0; bus.skip_en = 1'b0; bus.target = '0;
    model_pc = 13'h0000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_exec_valid", 32'(bus.exec_valid), 32'd0);
    chk("rst_exec_pc",    32'(bus.exec_pc),    32'd0);
    chk("rst_pm_flush",   32'(bus.pm_flush),   32'd1);
    chk("rst_pm_addr",    32'(bus.pm_addr),    32'd0);
    chk("rst_stk_ovf",    32'(bus.stk_ovf),    32'd0);
    chk("rst_stk_unf",    32'(bus.stk_unf),    32'd0);
    rst_n = 1'b1;

    // Start-up: one flush cycle, first word reaches instr on the 2nd edge.
    tick();
    chk("boot_flush_c1", 32'(s_flush), 32'd1);
    chk("boot_addr_c1",  32'(s_addr),  32'd0);
    tick();
    chk("boot_flush_c2", 32'(s_flush), 32'd0);
    chk("boot_valid_c2", 32'(s_valid), 32'd0);
    chk("boot_addr_c2",  32'(s_addr),  32'd1);
    run(4, used);
    chk("boot_run_cycles", 32'(used), 32'd4);

    // Wrap past the top of the address space with no bubble.
    do_jump(13'h1FFE);
    run(3, used);
    chk("wrap_cycles", 32'(used), 32'd5);

    // Plain jump: two flush cycles, two invalid instrs, then target.
    do_jump(13'h000C);
    run(4, used);
    do_jump(13'h0123);
    tick();
    chk("jump_flush_c2", 32'(s_flush), 32'd1);
    chk("jump_valid_c2", 32'(s_valid), 32'd0);
    tick();
    chk("jump_flush_c3", 32'(s_flush), 32'd0);
    chk("jump_valid_c3", 32'(s_valid), 32'd0);
    run(2, used);
    chk("jump_land_cycles", 32'(used), 32'd2);

    // Call/return round trip.
    do_jump(13'h004E);
    run(2, used);
    do_call(13'h0200);
    run(1, used);
    do_ret(13'h0051);
    run(3, used);
    chk("callret_ovf", 32'(bus.stk_ovf), 32'd0);
    chk("callret_unf", 32'(bus.stk_unf), 32'd0);

    // Nine nested calls then nine returns on an 8-deep circular stack.
    do_jump(13'h0100);
    run(1, used);
    for (int k = 0; k < 9; k++) begin
      ret_addr[k] = model_pc + AW'(1);
      do_call(AW'(13'h0300 + 13'h0020 * k));
      run(1, used);
      if (k == 7) chk("nest_ovf_after8", 32'(bus.stk_ovf), 32'd0);
      if (k == 8) chk("nest_ovf_after9", 32'(bus.stk_ovf), 32'd1);
    end
    for (int r = 0; r < 9; r++) begin
      if (r < 8) do_ret(ret_addr[8 - r]);
      else       do_ret(ret_addr[8]);
      run(1, used);
      if (r == 7) chk("nest_unf_after8", 32'(bus.stk_unf), 32'd0);
      if (r == 8) chk("nest_unf_after9", 32'(bus.stk_unf), 32'd1);
    end

    // Stall holds the instr and re-reads the in-flight word.
    do_jump(13'h003E);
    run(2, used);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_exec_pc", 32'(s_pc),    32'h040);
      chk("stall_valid",   32'(s_valid), 32'd1);
      chk("stall_pm_addr", 32'(s_addr),  32'h041);
      chk("stall_rd_en",   32'(s_rd_en), 32'd0);
    end
    bus.stall = 1'b0;
    run(3, used);
    chk("stall_release_cycles", 32'(used), 32'd3);

    // Skip: one bubble, lands two words on.
    do_jump(13'h005E);
    run(2, used);
    do_skip();
    run(2, used);
    chk("skip_cycles", 32'(used), 32'd3);

    // Redirect together with stall: redirect wins, fetch_pc is presented.
    bus.stall   = 1'b1;
    bus.jump_en = 1'b1;
    bus.target  = 13'h00AA;
    tick();
    chk("stalljump_flush", 32'(s_flush), 32'd1);
    chk("stalljump_addr",  32'(s_addr),  32'(model_pc + AW'(2)));
    bus.stall   = 1'b0;
    bus.jump_en = 1'b0;
    model_pc    = 13'h00AA;
    run(1, used);
    chk("stalljump_cycles", 32'(used), 32'd3);

    // Asynchronous reset in the middle of a stall.
    bus.stall = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_exec_valid", 32'(bus.exec_valid), 32'd0);
    chk("arst_pm_flush",   32'(bus.pm_flush),   32'd1);
    chk("arst_stk_unf",    32'(bus.stk_unf),    32'd0);
    chk("arst_stk_ovf",    32'(bus.stk_ovf),    32'd0);
    chk("arst_exec_pc",    32'(bus.exec_pc),    32'd0);
    bus.stall = 1'b0;
    exp_q.delete();
    model_pc = 13'h0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    run(3, used);
    chk("arst_restart_cycles", 32'(used), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
